ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

Parametrised AHB-Lite memory slave: next-generation successor of the fixed-configuration slave the AHB verification environment currently targets. It has configurable data width and depth, runtime-programmable wait states, byte/halfword/word (and doubleword at 64-bit) lane strobing, and a two-cycle ERROR response for illegal accesses. It sits behind the AHB decoder as a leaf slave and is the DUT for the next revision of the AHB testbench.

## Interface
- ADDR_W, 16: HADDR width in bits.
- DATA_W, 32: data bus width in bits; legal values 32 or 64.
- DEPTH, 1024: number of DATA_W-bit words; legal byte range is 0 .. DEPTH*DATA_W/8-1.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_W  byte address (address phase).
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of bytes.
- HBURST  in  3  burst type; accepted but ignored (addressing comes from the master).
- HWDATA  in  DATA_W  write data (data phase).
- HREADY  in  1  bus-level ready; gates acceptance of the address phase.
- wait_cfg  in  4  wait states inserted per OKAY transfer, 0..15.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_W  read data.

## Operation
- Acceptance: HSEL & HREADY & HTRANS[1]. At acceptance the block registers HADDR, HSIZE and HWRITE and samples wait_cfg into the wait counter. IDLE and BUSY, or an unselected bus, get a zero-wait OKAY response with no access.
- Error check at acceptance; any one of the following gives ERROR:
  - word index ≥ DEPTH;
  - HSIZE > log2(DATA_W/8);
  - address not aligned to the transfer size.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE → DATA on a legal acceptance; IDLE → ERR1 on an illegal acceptance.
  - DATA: HREADYOUT = (cnt == 0); cnt decrements each cycle while nonzero.
  - Exit from DATA when cnt == 0 (the completing cycle): → DATA/ERR1 if a new acceptance occurs in that cycle, otherwise → IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1. Always → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. Same next-state rules as the DATA completing cycle.
- Write: on the completing cycle's edge, byte lanes selected by HSIZE and HADDR[log2(DATA_W/8)-1:0] (little-endian) take HWDATA. Other lanes are unchanged. ERROR transfers never write.
- Read: during the completing cycle, HRDATA is the full addressed memory word, driven combinationally from the array. HRDATA is 0 in all other cycles.
- Back-to-back write followed by a read of the same address returns the new data, because the write commits before the read's data phase.
- Memory contents are not reset; reads of unwritten locations are X.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, cnt=0.
- Reset asserted mid-transfer abandons it; a pending write is not committed.
- Latency: OKAY data phase lasts 1 + wait_cfg cycles (wait_cfg sampled at acceptance; later changes do not affect an in-flight transfer).
- ERROR data phase always lasts 2 cycles, independent of wait_cfg.
- Pipelining: a new address phase may be accepted in any cycle where HREADYOUT=1. This gives one transfer per cycle with wait_cfg=0.
- An IDLE driven by the master during ERR2 is legal: the block returns to IDLE after ERR2.
- HREADY low while the block is unselected: no state change.

## Structure
- Shared package ahb_mem_pkg holds:
  - htrans_e, hsize_e, hresp_e enums;
  - state_e for the FSM;
  - localparam functions for lane count and the index width clog2(DEPTH).
- Sub-module ahb_mem_array: DEPTH×DATA_W storage with a byte-strobe write port and an asynchronous read port. The top level holds the FSM, error check, wait counter and lane decode.

## Test plan
- DATA_W=32, wait_cfg=0:
  - NONSEQ word write 0xDEADBEEF to 0x0010, then read 0x0010 back-to-back → HRDATA=0xDEADBEEF in the cycle after the read address phase, HREADYOUT never low.
  - Byte write 0xAA to 0x0013 over word 0x11223344 → read 0x0010 returns 0xAA223344.
- wait_cfg=3, read → HREADYOUT low for exactly 3 cycles, HRDATA valid on the 4th, HRESP=0.
- Error cases (wait_cfg=5 for the first):
  - Write to address DEPTH*4 → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, and the memory is unchanged.
  - Misaligned halfword to 0x0001 → same 2-cycle ERROR response.
- DATA_W=64: doubleword write 0x0123456789ABCDEF to 0x0008, then halfword read 0x000C → HRDATA=0x0123456789ABCDEF.
- HRESETn low during the second wait state of a write → HREADYOUT=1 and HRESP=0 immediately; a later read of that address shows the old value.

Source files
------------

// File: rtl/ahb_mem_pkg.sv
// ahb_mem_pkg
//   Shared types and sizing helpers for the AHB-Lite memory slave.
//   htrans_e / hsize_e / hresp_e : AHB bus encodings
//   state_e                      : slave FSM states
//   lane_count / lane_off_w / index_w : geometry derived from DATA_W and DEPTH
package ahb_mem_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_DWORD = 3'd3,
        SZ_4WORD = 3'd4,
        SZ_8WORD = 3'd5,
        SZ_16W   = 3'd6,
        SZ_32W   = 3'd7
    } hsize_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    // state    | meaning
    // ST_IDLE  | no data phase in progress, ready for an address phase
    // ST_DATA  | OKAY data phase, counting down wait states
    // ST_ERR1  | first ERROR cycle (HREADYOUT low)
    // ST_ERR2  | second ERROR cycle (HREADYOUT high)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int index_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array
//   DEPTH x DATA_W storage, no reset.
//   clk    : write clock
//   we     : write enable; strb selects byte lanes of wdata written to word widx
//   ridx   : asynchronous read index, rdata is the full stored word
module ahb_mem_array
    import ahb_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int LANES = lane_count(DATA_W),
    localparam int IDX_W = index_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [LANES-1:0]  strb,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (strb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave
//   AHB-Lite leaf memory slave with programmable wait states, byte-lane
//   strobing and a two-cycle ERROR response.
//   Bus inputs : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST (ignored), HWDATA, HREADY
//   Config     : wait_cfg, wait states per OKAY transfer, sampled at acceptance
//   Outputs    : HREADYOUT, HRESP (registered), HRDATA (from the array during
//                the completing cycle of a read, zero otherwise)
module ahb_mem_slave
    import ahb_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [3:0]        wait_cfg,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int          LANES    = lane_count(DATA_W);
    localparam int          OFF_W    = lane_off_w(DATA_W);
    localparam int          IDX_W    = index_w(DEPTH);
    localparam int          AQ_W     = OFF_W + IDX_W;
    localparam logic [63:0] BYTES    = 64'(DEPTH) * 64'(LANES);
    localparam logic [2:0]  MAX_SIZE = 3'(OFF_W);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              hready_q, hready_d;
    hresp_e            hresp_q, hresp_d;

    logic              accept;
    logic              err_range, err_size, err_align, acc_err;
    logic              data_done;
    logic              mem_we;
    logic [LANES-1:0]  wr_strb;
    logic [DATA_W-1:0] mem_rdata;
    int                lane_lo, lane_hi;
    logic              unused_burst;

    assign unused_burst = ^HBURST;

    // hready_q gates acceptance so a wait-stated data phase can never be
    // overlapped, even if the bus-level HREADY misbehaves.
    assign accept = HSEL && HREADY && hready_q &&
                    (htrans_e'(HTRANS) == TR_NONSEQ || htrans_e'(HTRANS) == TR_SEQ);

    always_comb begin
        err_range = 64'(HADDR) >= BYTES;
        err_size  = HSIZE > MAX_SIZE;
        err_align = 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (b < int'(HSIZE)) begin
                err_align = err_align | HADDR[b];
            end
        end
        acc_err = err_range || err_size || err_align;
    end

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (state_q == ST_DATA && cnt_q != 4'd0) begin
            state_d = ST_DATA;
            cnt_d   = cnt_q - 4'd1;
        end else if (accept) begin
            addr_d  = HADDR[AQ_W-1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            if (acc_err) begin
                state_d = ST_ERR1;
                cnt_d   = 4'd0;
            end else begin
                state_d = ST_DATA;
                cnt_d   = wait_cfg;
            end
        end
        // Outputs are derived from the next state so they can be registered.
        hready_d = (state_d == ST_DATA) ? (cnt_d == 4'd0) : (state_d != ST_ERR1);
        hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    assign data_done = (state_q == ST_DATA) && (cnt_q == 4'd0);
    assign mem_we    = data_done && write_q;

    // Lanes covered by the transfer: [offset, offset + 2**size).
    always_comb begin
        wr_strb = '0;
        lane_lo = int'(addr_q[OFF_W-1:0]);
        lane_hi = lane_lo + (32'd1 << size_q);
        for (int i = 0; i < LANES; i++) begin
            if (i >= lane_lo && i < lane_hi) begin
                wr_strb[i] = 1'b1;
            end
        end
    end

    ahb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (HCLK),
        .we    (mem_we),
        .widx  (addr_q[AQ_W-1:OFF_W]),
        .strb  (wr_strb),
        .wdata (HWDATA),
        .ridx  (addr_q[AQ_W-1:OFF_W]),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (data_done && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
module tb_ahb_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite, use64;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [63:0] hwdata;
    logic [3:0]  wait_cfg;

    logic        ro32, rs32, ro64, rs64;
    logic [31:0] rd32;
    logic [63:0] rd64;
    logic        rdy_o, resp_o;
    logic [63:0] rdata_o;

    int checks = 0;
    int errors = 0;

    bit [7:0] mm [64];

    always #5 clk = ~clk;

    assign rdy_o   = use64 ? ro64 : ro32;
    assign resp_o  = use64 ? rs64 : rs32;
    assign rdata_o = use64 ? rd64 : {32'd0, rd32};

    ahb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024)) dut32 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~use64), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata[31:0]), .HREADY(ro32), .wait_cfg(wait_cfg),
        .HREADYOUT(ro32), .HRESP(rs32), .HRDATA(rd32)
    );

    ahb_mem_slave #(.ADDR_W(16), .DATA_W(64), .DEPTH(1024)) dut64 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & use64), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(ro64), .wait_cfg(wait_cfg),
        .HREADYOUT(ro64), .HRESP(rs64), .HRDATA(rd64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for the 32-bit slave, byte addressed over 0..63.
    function automatic logic [63:0] m_read(input int addr);
        int b;
        b = addr & ~3;
        return {32'd0, mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    function automatic void m_write(input int addr, input int size, input logic [63:0] wd);
        int off;
        off = addr % 4;
        for (int i = off; i < off + (1 << size); i++) mm[(addr & ~3) + i] = wd[8*i +: 8];
    endfunction

    function automatic bit m_err(input int addr, input int size, input int bytes, input int maxsz);
        return (size > maxsz) || (addr >= bytes) || ((addr % (1 << size)) != 0);
    endfunction

    // Entered and left at posedge+1. The address phase is driven in the
    // current cycle, so consecutive calls are pipelined.
    task automatic xfer(input bit w, input int addr, input int size, input logic [63:0] wd,
                        input int wcfg, input bit exp_err, input logic [63:0] exp_rd,
                        input bit chk_rd);
        int waits;
        int exp_waits;
        hsel     = 1'b1;
        htrans   = 2'd2;
        haddr    = addr[15:0];
        hwrite   = w;
        hsize    = size[2:0];
        wait_cfg = wcfg[3:0];
        @(posedge clk); #1;
        hsel     = 1'b0;
        htrans   = 2'd0;
        hwdata   = wd;
        wait_cfg = 4'($urandom);
        waits    = 0;
        exp_waits = exp_err ? 1 : wcfg;
        while (rdy_o !== 1'b1 && waits < 40) begin
            chk("wait_resp", 64'(resp_o), 64'(exp_err));
            chk("wait_rdata", rdata_o, 64'd0);
            waits++;
            @(posedge clk); #1;
        end
        chk("wait_count", 64'(waits), 64'(exp_waits));
        chk("done_resp", 64'(resp_o), 64'(exp_err));
        chk("done_rdata", rdata_o, chk_rd ? exp_rd : 64'd0);
    endtask

    initial begin
        int addr, size, wcfg;
        bit w, e;
        logic [63:0] wd;

        rst_n = 1'b0; use64 = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0;
        htrans = 2'd0; hsize = 3'd0; hburst = 3'd0; hwdata = '0; wait_cfg = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready32", 64'(ro32), 64'd1);
        chk("rst_resp32", 64'(rs32), 64'd0);
        chk("rst_rdata32", 64'(rd32), 64'd0);
        chk("rst_ready64", 64'(ro64), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            wd = {32'd0, $urandom};
            xfer(1'b1, 4*i, 2, wd, 0, 1'b0, 64'd0, 1'b0);
            m_write(4*i, 2, wd);
        end

        // Back-to-back write/read, no wait states.
        xfer(1'b1, 'h10, 2, 64'hDEADBEEF, 0, 1'b0, 64'd0, 1'b0);
        m_write('h10, 2, 64'hDEADBEEF);
        xfer(1'b0, 'h10, 2, 64'd0, 0, 1'b0, 64'hDEADBEEF, 1'b1);

        // Byte lane write.
        xfer(1'b1, 'h10, 2, 64'h11223344, 0, 1'b0, 64'd0, 1'b0);
        m_write('h10, 2, 64'h11223344);
        xfer(1'b1, 'h13, 0, 64'hAA00_0000, 0, 1'b0, 64'd0, 1'b0);
        m_write('h13, 0, 64'hAA00_0000);
        xfer(1'b0, 'h10, 2, 64'd0, 0, 1'b0, 64'hAA223344, 1'b1);

        // Three wait states on a read.
        xfer(1'b0, 'h10, 2, 64'd0, 3, 1'b0, m_read('h10), 1'b1);

        // Out-of-range write, then misaligned halfword, then confirm word 0.
        xfer(1'b1, 4096, 2, 64'h5555AAAA, 5, 1'b1, 64'd0, 1'b0);
        xfer(1'b0, 1, 1, 64'd0, 0, 1'b1, 64'd0, 1'b0);
        xfer(1'b0, 0, 2, 64'd0, 0, 1'b0, m_read(0), 1'b1);

        // Reset during the second wait state of a write.
        hsel = 1'b1; htrans = 2'd2; haddr = 16'h0020; hwrite = 1'b1;
        hsize = 3'd2; wait_cfg = 4'd3;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 64'hCAFEF00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 64'(ro32), 64'd1);
        chk("rstmid_resp", 64'(rs32), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 'h20, 2, 64'd0, 0, 1'b0, m_read('h20), 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 80; n++) begin
            w    = 1'($urandom_range(0, 1));
            size = $urandom_range(0, 3);
            addr = ($urandom_range(0, 9) == 0) ? 4096 + $urandom_range(0, 63) : $urandom_range(0, 63);
            wd   = {$urandom, $urandom};
            wcfg = $urandom_range(0, 4);
            e    = m_err(addr, size, 4096, 2);
            xfer(w, addr, size, wd, wcfg, e, e ? 64'd0 : m_read(addr), !w && !e);
            if (w && !e) m_write(addr, size, wd);
        end

        // 64-bit slave: doubleword write, halfword read returns full word.
        use64 = 1'b1;
        xfer(1'b1, 'h8, 3, 64'h0123456789ABCDEF, 0, 1'b0, 64'd0, 1'b0);
        xfer(1'b0, 'hC, 1, 64'd0, 0, 1'b0, 64'h0123456789ABCDEF, 1'b1);
        xfer(1'b0, 'h4, 3, 64'd0, 0, 1'b1, 64'd0, 1'b0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
